// File: rtl/rvx_set_bit_iterator.sv
// Walks the set bits of an accepted vector, one bit per beat,
// lowest-first or highest-first depending on LSB_FIRST.
module rvx_set_bit_iterator #(
   parameter int WIDTH = 8,
   parameter int LSB_FIRST = 1,
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rstnn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vector,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_onehot,
   output logic [IW-1:0]    out_index,
   output logic             out_last,
   output logic             busy
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [WIDTH-1:0] sel;
   logic [WIDTH-1:0] rest;
   logic [IW-1:0]    idx;
   logic             scan;
   logic             last;
   logic             out_hs;
   logic             in_hs;

   // Later loop iterations win, so the scan direction picks the priority end.
   always_comb begin
      sel = '0;
      if (LSB_FIRST == 1) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
               sel    = '0;
               sel[i] = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (pending_q[i]) begin
               sel    = '0;
               sel[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sel[i]) begin
            idx = idx | IW'(i);
         end
      end
   end

   assign scan = (state_q == SCAN);
   assign rest = pending_q & ~sel;
   assign last = scan && (rest == '0);
   assign out_hs = scan && out_ready;

   // in_ready is gated by rstnn so it reads 0 throughout reset.
   assign in_ready = rstnn && !flush && (!scan || (out_hs && last));
   assign in_hs = in_valid && in_ready;

   assign out_valid  = scan;
   assign busy       = scan;
   assign out_onehot = scan ? sel : '0;
   assign out_index  = scan ? idx : '0;
   assign out_last   = last;

   always_comb begin
      pending_d = pending_q;
      state_d   = state_q;
      if (flush) begin
         pending_d = '0;
         state_d   = IDLE;
      end else begin
         if (out_hs) begin
            pending_d = rest;
         end
         if (in_hs && (in_vector != '0)) begin
            pending_d = in_vector;
         end
         state_d = (pending_d != '0) ? SCAN : IDLE;
      end
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         pending_q <= '0;
         state_q   <= IDLE;
      end else begin
         pending_q <= pending_d;
         state_q   <= state_d;
      end
   end

endmodule

// File: doc/rvx_set_bit_iterator.md
RVX_SET_BIT_ITERATOR -- requirements
Module: rvx_set_bit_iterator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the vector width (legal range >= 1).
REQ-002 The block SHALL have parameter LSB_FIRST, default 1: 1 = emit lowest set index first; any other value = emit highest set index first.
REQ-003 The block SHALL use local IW = max(1, clog2(WIDTH)) as the index width.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rstnn  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous clear of all in-flight work.
REQ-007 in_valid  input  1  in_vector is valid.
REQ-008 in_ready  output  1  block accepts in_vector this cycle.
REQ-009 in_vector  input  WIDTH  multi-bit request vector.
REQ-010 out_valid  output  1  out_onehot, out_index and out_last are valid.
REQ-011 out_ready  input  1  consumer accepts the current beat.
REQ-012 out_onehot  output  WIDTH  single selected bit.
REQ-013 out_index  output  IW  binary index of the selected bit.
REQ-014 out_last  output  1  current beat is the final set bit of the vector.
REQ-015 busy  output  1  a vector is being iterated (equals out_valid).

Function
REQ-016 The block SHALL hold a WIDTH-bit pending register and a two-state FSM: IDLE (pending==0) and SCAN (pending!=0).
REQ-017 An input handshake SHALL occur when in_valid & in_ready; an output handshake SHALL occur when out_valid & out_ready.
REQ-018 in_ready SHALL be 1 in IDLE, or in SCAN when an output handshake with out_last=1 occurs that cycle; otherwise 0; it SHALL be 0 when flush=1.
REQ-019 On an input handshake with a nonzero in_vector, pending SHALL load in_vector and the FSM SHALL enter or stay in SCAN; the first beat SHALL appear one cycle later (latency 1).
REQ-020 On an input handshake with in_vector==0, the vector SHALL be consumed with no output beat, and the FSM SHALL stay in IDLE.
REQ-021 out_valid SHALL be 1 exactly in SCAN.
REQ-022 out_onehot SHALL be the lowest set bit of pending (LSB_FIRST=1) or the highest set bit (otherwise), derived combinationally from pending.
REQ-023 out_index SHALL be the binary position of out_onehot; out_onehot and out_index SHALL be 0 in IDLE.
REQ-024 out_last SHALL be 1 iff (pending & ~out_onehot)==0 while in SCAN; it SHALL be 0 in IDLE.
REQ-025 On an output handshake, pending SHALL become pending & ~out_onehot; when out_last=1 the FSM SHALL return to IDLE unless the same cycle's input handshake loads a nonzero vector.
REQ-026 With out_ready=0, all outputs SHALL hold stable.
REQ-027 Throughput SHALL be one beat per cycle, with no bubble between consecutive vectors.
REQ-028 flush=1 SHALL clear pending to 0 and force IDLE on the next edge, with priority over every handshake; in_vector SHALL NOT be accepted in that cycle.

Reset
REQ-029 While rstnn=0: pending=0, FSM=IDLE, out_valid=0, busy=0, out_onehot=0, out_index=0, out_last=0, in_ready=0.
REQ-030 Reset assertion mid-scan SHALL abort the vector immediately (asynchronously); after release the block SHALL be IDLE with in_ready=1.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-031 LSB_FIRST=1, in_vector=0xA4 -> beats (0x04,2,0),(0x20,5,0),(0x80,7,1) on 3 consecutive cycles starting 1 cycle after accept.
REQ-032 LSB_FIRST=0, in_vector=0xA4 -> beats (0x80,7,0),(0x20,5,0),(0x04,2,1).
REQ-033 in_vector=0xFF, out_ready low on beats 2-4 -> 8 beats with indices 0..7 in order, outputs held stable while stalled, out_last only on index 7.
REQ-034 0x81 followed immediately by 0x01 presented with in_valid=1 during the last beat -> beats 0,7(last),0(last) with no idle cycle between them.
REQ-035 in_vector=0x00 accepted -> no out_valid; in_ready stays 1.
REQ-036 flush asserted after the first beat of 0x0F -> out_valid=0 next cycle; reset (rstnn low) mid-scan of 0xF0 -> all outputs 0 immediately; next vector 0x02 -> single beat (0x02,1,1).
